// File: rtl/dft_lbist_chains_pkg.sv
// -----------------------------------------------------------------------------
// dft_pkg
// Shared definitions for the LBIST scan-chain block:
//   SIG_W          width of the PRPG/MISR registers and of the signature port
//   LFSR_TAPS      tap mask of x^16+x^14+x^13+x^11+1 (register bits 15,13,12,10)
//   lbist_state_e  LBIST controller states
// -----------------------------------------------------------------------------
package dft_pkg;

  localparam int SIG_W = 16;

  localparam logic [SIG_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } lbist_state_e;

endpackage

// File: rtl/dft_lbist_chains_misr16.sv
// -----------------------------------------------------------------------------
// dft_misr16
// 16-bit Fibonacci shift register.
// It is used both as the pattern generator (PRPG, data_in tied to zero) and as
// the signature register (MISR). It shifts toward the MSB, and the XOR of the
// tapped bits feeds bit 0.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (register resets to SEED)
//   en          advance one step, XOR-ing data_in into the new value
//   load        reload SEED (has priority over en)
//   data_in     parallel data compressed into the register
//   value_o     current register contents
// -----------------------------------------------------------------------------
module dft_misr16
  import dft_pkg::*;
#(
  parameter logic [SIG_W-1:0] SEED = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [SIG_W-1:0] data_in,
  output logic [SIG_W-1:0] value_o
);

  logic [SIG_W-1:0] reg_q;
  logic [SIG_W-1:0] reg_d;
  logic             fb;

  always_comb begin
    fb    = ^(reg_q & LFSR_TAPS);
    reg_d = reg_q;
    if (load) begin
      reg_d = SEED;
    end else if (en) begin
      reg_d = {reg_q[SIG_W-2:0], fb} ^ data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= SEED;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign value_o = reg_q;

endmodule

// File: rtl/dft_lbist_chains.sv
// -----------------------------------------------------------------------------
// dft_lbist_chains
// The block has NUM_CHAINS scan chains of CHAIN_LEN flops each. It also has an
// optional logic-BIST controller, which is built only when the macro
// DFT_LBIST_EN is defined.
// Functional mode: each chain counts up by one per cycle (modulo 2^CHAIN_LEN).
// Scan mode:       scan_en shifts scan_in[i] into the LSB of chain i.
// LBIST run: the run executes PATTERNS times SHIFT (CHAIN_LEN cycles) followed
// by CAPTURE. It then does UNLOAD (CHAIN_LEN cycles) and COMPARE, and ends in
// DONE. During shifting the PRPG feeds the chains, and the MISR compresses
// scan_out.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   scan_en      scan shift enable. It has highest priority and aborts a run.
//   scan_in      serial input per chain
//   scan_out     MSB of each chain
//   bist_start   starts a run (from IDLE or DONE, when scan_en is low)
//   bist_busy    run in progress
//   bist_done    sticky completion flag
//   bist_fail    sticky signature-mismatch flag, valid with bist_done
//   signature    current MISR contents
// When DFT_LBIST_EN is undefined, the controller is absent. In that build,
// bist_done reads 1, bist_busy/bist_fail read 0 and signature reads 0.
// -----------------------------------------------------------------------------
module dft_lbist_chains
  import dft_pkg::*;
#(
  parameter int               NUM_CHAINS = 4,
  parameter int               CHAIN_LEN  = 4,
  parameter int               PATTERNS   = 8,
  parameter logic [SIG_W-1:0] LFSR_SEED  = 16'hACE1,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_en,
  input  logic [NUM_CHAINS-1:0] scan_in,
  output logic [NUM_CHAINS-1:0] scan_out,
  input  logic                  bist_start,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  output logic [SIG_W-1:0]      signature
);

  logic [CHAIN_LEN-1:0]  chain_q [NUM_CHAINS];
  logic [CHAIN_LEN-1:0]  chain_d [NUM_CHAINS];
  logic [NUM_CHAINS-1:0] chain_src;   // serial bit entering each chain
  logic                  shift_mode;
  logic                  func_mode;

`ifdef DFT_LBIST_EN
  localparam int SCW = $clog2(CHAIN_LEN + 1);
  localparam int PW  = $clog2(PATTERNS + 1);

  lbist_state_e     state_q, state_d;
  logic [SCW-1:0]   sh_cnt_q, sh_cnt_d;
  logic [PW-1:0]    pat_cnt_q, pat_cnt_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             run_start;
  logic             lbist_shift;
  logic [SIG_W-1:0] prpg_val;
  logic [SIG_W-1:0] misr_val;

  dft_misr16 #(.SEED(LFSR_SEED)) u_prpg (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (lbist_shift),
    .load    (run_start),
    .data_in ('0),
    .value_o (prpg_val)
  );

  dft_misr16 #(.SEED('0)) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (lbist_shift),
    .load    (run_start),
    .data_in (SIG_W'(scan_out)),
    .value_o (misr_val)
  );

  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    done_d      = done_q;
    fail_d      = fail_q;
    run_start   = 1'b0;
    lbist_shift = 1'b0;
    if (scan_en) begin
      // External scan takes the chains over; an active run is abandoned.
      if (bist_busy) begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        fail_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bist_start) begin
            state_d   = ST_SHIFT;
            run_start = 1'b1;
            sh_cnt_d  = '0;
            pat_cnt_d = '0;
            done_d    = 1'b0;
            fail_d    = 1'b0;
          end
        end
        ST_SHIFT, ST_UNLOAD: begin
          lbist_shift = 1'b1;
          if (sh_cnt_q == SCW'(CHAIN_LEN - 1)) begin
            sh_cnt_d = '0;
            state_d  = (state_q == ST_SHIFT) ? ST_CAPTURE : ST_COMPARE;
          end else begin
            sh_cnt_d = sh_cnt_q + SCW'(1);
          end
        end
        ST_CAPTURE: begin
          pat_cnt_d = pat_cnt_q + PW'(1);
          state_d   = (pat_cnt_q == PW'(PATTERNS - 1)) ? ST_UNLOAD : ST_SHIFT;
        end
        ST_COMPARE: begin
          done_d  = 1'b1;
          fail_d  = (misr_val != GOLDEN_SIG);
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sh_cnt_q  <= '0;
      pat_cnt_q <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign shift_mode = scan_en | lbist_shift;
  assign func_mode  = ~scan_en & ((state_q == ST_IDLE) | (state_q == ST_DONE) |
                                  (state_q == ST_CAPTURE));
  assign chain_src  = scan_en ? scan_in : prpg_val[NUM_CHAINS-1:0];
  assign bist_busy  = (state_q == ST_SHIFT) | (state_q == ST_CAPTURE) |
                      (state_q == ST_UNLOAD) | (state_q == ST_COMPARE);
  assign bist_done  = done_q;
  assign bist_fail  = fail_q;
  assign signature  = misr_val;
`else
  localparam int unused_params = int'(LFSR_SEED ^ GOLDEN_SIG) + PATTERNS;
  logic unused_start;

  assign unused_start = bist_start;
  assign shift_mode   = scan_en;
  assign func_mode    = ~scan_en;
  assign chain_src    = scan_in;
  assign bist_busy    = 1'b0;
  assign bist_done    = 1'b1;
  assign bist_fail    = 1'b0;
  assign signature    = '0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_CHAINS; i++) begin
      chain_d[i] = chain_q[i];
      if (shift_mode) begin
        chain_d[i] = {chain_q[i][CHAIN_LEN-2:0], chain_src[i]};
      end else if (func_mode) begin
        chain_d[i] = chain_q[i] + CHAIN_LEN'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CHAINS; i++) begin
      scan_out[i] = chain_q[i][CHAIN_LEN-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHAINS; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHAINS; i++) begin
        chain_q[i] <= chain_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dft_lbist_chains.sv
// -----------------------------------------------------------------------------
// tb_dft_lbist_chains
// Scoreboard bench for dft_lbist_chains with the default parameters (4x4 chains,
// 8 patterns). Each driven cycle pushes the reference model's post-edge outputs.
// They are popped and compared after the edge. The LBIST sections are built
// only when DFT_LBIST_EN is defined.
// -----------------------------------------------------------------------------
module tb_dft_lbist_chains;

  localparam logic [15:0] SEED = 16'hACE1;

`ifdef DFT_LBIST_EN
  localparam bit LB_EN = 1'b1;
`else
  localparam bit LB_EN = 1'b0;
`endif

  function automatic logic [15:0] step16(input logic [15:0] r);
    return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
  endfunction

  // Signature of a run that starts with every chain holding 1.
  function automatic logic [15:0] golden_sig();
    logic [3:0][3:0] ch;
    logic [15:0]     lf;
    logic [15:0]     ms;
    logic [3:0]      so;
    lf = SEED;
    ms = 16'h0000;
    for (int i = 0; i < 4; i++) ch[i] = 4'd1;
    for (int p = 0; p <= 8; p++) begin
      for (int s = 0; s < 4; s++) begin
        for (int i = 0; i < 4; i++) so[i] = ch[i][3];
        ms = step16(ms) ^ {12'd0, so};
        for (int i = 0; i < 4; i++) ch[i] = {ch[i][2:0], lf[i]};
        lf = step16(lf);
      end
      if (p < 8) begin
        for (int i = 0; i < 4; i++) ch[i] = ch[i] + 4'd1;
      end
    end
    return ms;
  endfunction

  localparam logic [15:0] GOLD = golden_sig();

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic [3:0]  scan_in = 4'h0;
  logic        bist_start = 1'b0;
  logic [3:0]  scan_out, f_scan_out;
  logic        bist_busy, bist_done, bist_fail;
  logic        f_busy, f_done, f_fail;
  logic [15:0] signature, f_signature;

  always #5 clk = ~clk;

  dft_lbist_chains #(.GOLDEN_SIG(GOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .bist_start (bist_start),
    .bist_busy  (bist_busy),
    .bist_done  (bist_done),
    .bist_fail  (bist_fail),
    .signature  (signature)
  );

  dft_lbist_chains #(.GOLDEN_SIG(GOLD ^ 16'h0001)) dut_f (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (f_scan_out),
    .bist_start (bist_start),
    .bist_busy  (f_busy),
    .bist_done  (f_done),
    .bist_fail  (f_fail),
    .signature  (f_signature)
  );

  typedef struct packed {
    logic [3:0]  so;
    logic        busy;
    logic        done;
    logic        fail;
    logic [15:0] sig;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  logic [3:0]  m_ch [4];
  int          m_st;      // 0 idle,1 shift,2 capture,3 unload,4 compare,5 done
  int          m_cnt, m_pat;
  logic [15:0] m_lfsr, m_misr;
  logic        m_done, m_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ch[i] = 4'h0;
    m_st = 0; m_cnt = 0; m_pat = 0;
    m_lfsr = SEED; m_misr = 16'h0000;
    m_done = 1'b0; m_fail = 1'b0;
  endtask

  task automatic model_step(input logic se, input logic [3:0] si, input logic st);
    logic [3:0] so;
    for (int i = 0; i < 4; i++) so[i] = m_ch[i][3];
    if (se) begin
      for (int i = 0; i < 4; i++) m_ch[i] = {m_ch[i][2:0], si[i]};
      if (LB_EN && m_st >= 1 && m_st <= 4) begin
        m_st = 0; m_done = 1'b0; m_fail = 1'b0;
      end
    end else if (!LB_EN) begin
      for (int i = 0; i < 4; i++) m_ch[i] = m_ch[i] + 4'd1;
    end else begin
      case (m_st)
        1, 3: begin
          m_misr = step16(m_misr) ^ {12'd0, so};
          for (int i = 0; i < 4; i++) m_ch[i] = {m_ch[i][2:0], m_lfsr[i]};
          m_lfsr = step16(m_lfsr);
          m_cnt++;
          if (m_cnt == 4) begin
            m_cnt = 0;
            m_st  = (m_st == 1) ? 2 : 4;
          end
        end
        2: begin
          for (int i = 0; i < 4; i++) m_ch[i] = m_ch[i] + 4'd1;
          m_pat++;
          m_st = (m_pat == 8) ? 3 : 1;
        end
        4: begin
          m_done = 1'b1;
          m_fail = (m_misr != GOLD);
          m_st   = 5;
        end
        default: begin
          for (int i = 0; i < 4; i++) m_ch[i] = m_ch[i] + 4'd1;
          if (st) begin
            m_st = 1; m_cnt = 0; m_pat = 0;
            m_lfsr = SEED; m_misr = 16'h0000;
            m_done = 1'b0; m_fail = 1'b0;
          end
        end
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < 4; i++) e.so[i] = m_ch[i][3];
    if (LB_EN) begin
      e.busy = (m_st >= 1 && m_st <= 4);
      e.done = m_done;
      e.fail = m_fail;
      e.sig  = m_misr;
    end else begin
      e.busy = 1'b0;
      e.done = 1'b1;
      e.fail = 1'b0;
      e.sig  = 16'h0000;
    end
    return e;
  endfunction

  // Called at a falling edge; drives, clocks once, compares, returns at the next falling edge.
  task automatic cycle(input logic se, input logic [3:0] si, input logic st);
    exp_t e;
    scan_en    = se;
    scan_in    = si;
    bist_start = st;
    model_step(se, si, st);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("scan_out", scan_out, e.so);
      chk("busy", bist_busy, e.busy);
      chk("done", bist_done, e.done);
      chk("fail", bist_fail, e.fail);
      chk("signature", signature, e.sig);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_scan_out"}, scan_out, 4'h0);
    chk({tag, "_busy"}, bist_busy, 1'b0);
    chk({tag, "_done"}, bist_done, LB_EN ? 1'b0 : 1'b1);
    chk({tag, "_fail"}, bist_fail, 1'b0);
    chk({tag, "_sig"}, signature, 16'h0000);
  endtask

  task automatic load_zeros();
    for (int k = 0; k < 4; k++) cycle(1'b1, 4'h0, 1'b0);
  endtask

  // Start a run and step through it; abort_at > 0 raises scan_en on that edge.
  task automatic run_bist(input int abort_at);
    cycle(1'b0, 4'h0, 1'b1);
    chk("run_e0_busy", bist_busy, LB_EN);
    for (int k = 1; k <= 45; k++) begin
      if (k == abort_at) begin
        cycle(1'b1, 4'h0, 1'b0);
        chk("abort_busy", bist_busy, 1'b0);
        chk("abort_done", bist_done, 1'b0);
        return;
      end
      cycle(1'b0, 4'h0, (k == 5));
      chk($sformatf("busy_e%0d", k), bist_busy, (k < 45));
      chk($sformatf("done_e%0d", k), bist_done, (k == 45));
    end
    chk("run_sig_golden", signature, GOLD);
    chk("run_fail_pass", bist_fail, 1'b0);
    chk("run_fail_xor1_done", f_done, 1'b1);
    chk("run_fail_xor1", f_fail, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    logic [3:0] cv [4];
    model_reset();
    #2;
    check_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan in 1,0,1,1 on chain 0, then one functional cycle.
    cycle(1'b1, 4'b0101, 1'b0);
    cycle(1'b1, 4'b1010, 1'b0);
    cycle(1'b1, 4'b0011, 1'b0);
    cycle(1'b1, 4'b1101, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    v = 4'h0;
    for (int k = 0; k < 4; k++) begin
      v = {v[2:0], scan_out[0]};
      cycle(1'b1, 4'h0, 1'b0);
    end
    chk("chain0_func", v, 4'b1100);

    // Wrap: all ones plus one functional update gives zero.
    for (int k = 0; k < 4; k++) cycle(1'b1, 4'hF, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) cv[i] = 4'h0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) cv[i] = {cv[i][2:0], scan_out[i]};
      cycle(1'b1, 4'h0, 1'b0);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_chain%0d", i), cv[i], 4'b0000);

    // Free-running functional counting with random scan bursts.
    for (int k = 0; k < 12; k++) cycle(k[2], 4'($urandom_range(0, 15)), 1'b0);

`ifdef DFT_LBIST_EN
    load_zeros();
    run_bist(0);
    // Start together with scan_en is ignored.
    cycle(1'b1, 4'h0, 1'b1);
    chk("start_with_scan_busy", bist_busy, 1'b0);

    // Abort at edge 10, then a clean rerun.
    load_zeros();
    run_bist(10);
    load_zeros();
    run_bist(0);

    // Reset in the middle of a run.
    load_zeros();
    cycle(1'b0, 4'h0, 1'b1);
    for (int k = 0; k < 7; k++) cycle(1'b0, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cycle(1'b0, 4'h0, 1'b0);
`else
    for (int k = 0; k < 10; k++) cycle(1'b0, 4'h0, k[0]);
    chk("nolb_done", bist_done, 1'b1);
    chk("nolb_busy", bist_busy, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
